// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line and receive-result signals of the UART receiver
//  tick          oversample strobe, OS_RATE pulses per bit (master -> slave)
//  rx            serial line, idle high (master -> slave)
//  rx_data       last correctly framed word (slave -> master)
//  rx_done       1-clk pulse, rx_data updated (slave -> master)
//  rx_frame_err  1-clk pulse, stop bit sampled low (slave -> master)
//  rx_busy       frame in progress (slave -> master)
//  rx_parity_err 1-clk pulse on parity mismatch, only with UART_RX_PARITY_EN
interface uart_rx_if #(
   parameter int DATA_BITS = 8
);
   logic                 tick;
   logic                 rx;
   logic [DATA_BITS-1:0] rx_data;
   logic                 rx_done;
   logic                 rx_frame_err;
   logic                 rx_busy;
`ifdef UART_RX_PARITY_EN
   logic                 rx_parity_err;
   modport master (output tick, rx, input rx_data, rx_done, rx_frame_err, rx_busy, rx_parity_err);
   modport slave  (input tick, rx, output rx_data, rx_done, rx_frame_err, rx_busy, rx_parity_err);
`else
   modport master (output tick, rx, input rx_data, rx_done, rx_frame_err, rx_busy);
   modport slave  (input tick, rx, output rx_data, rx_done, rx_frame_err, rx_busy);
`endif
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampled UART receiver, LSB-first frames with one stop bit
//  clk  system clock, rst synchronous active-high reset
//  bus  uart_rx_if.slave: tick/rx in; rx_data, rx_done, rx_frame_err,
//       rx_busy (and rx_parity_err) out
//  Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx #(
   parameter int DATA_BITS = 8,
   parameter int OS_RATE   = 16
) (
   input  logic     clk,
   input  logic     rst,
   uart_rx_if.slave bus
);
   localparam int TW = $clog2(OS_RATE);
   localparam int BW = $clog2(DATA_BITS);
`ifdef UART_RX_PARITY_EN
   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BRK} state_t;
   logic par_q, perr_q;
`else
   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BRK} state_t;
`endif
   state_t               state_q;
   logic                 rx_meta_q, rx_s_q;
   logic [TW-1:0]        tick_q;
   logic [BW-1:0]        bit_q;
   logic [DATA_BITS-1:0] sh_q, data_q;
   logic                 done_q, ferr_q, busy_q;
   logic                 at_lim;
   // START waits half a bit to land mid-bit; later states wait a full bit
   assign at_lim = bus.tick && tick_q == ((state_q == START) ? TW'(OS_RATE / 2 - 1) : TW'(OS_RATE - 1));
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta_q <= 1'b1;
         rx_s_q    <= 1'b1;
         state_q   <= IDLE;
         tick_q    <= '0;
         bit_q     <= '0;
         sh_q      <= '0;
         data_q    <= '0;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
         busy_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         par_q     <= 1'b0;
         perr_q    <= 1'b0;
`endif
      end else begin
         rx_meta_q <= bus.rx;
         rx_s_q    <= rx_meta_q;
         done_q    <= 1'b0;
         ferr_q    <= 1'b0;
`ifdef UART_RX_PARITY_EN
         perr_q    <= 1'b0;
`endif
         if (bus.tick) tick_q <= at_lim ? '0 : tick_q + 1'b1;
         case (state_q)
            IDLE: begin
               tick_q <= '0;
               if (!rx_s_q) state_q <= START;
            end
            START: if (at_lim) begin
               state_q <= rx_s_q ? IDLE : DATA;
               busy_q  <= !rx_s_q;
               bit_q   <= '0;
            end
            DATA: if (at_lim) begin
               sh_q  <= {rx_s_q, sh_q[DATA_BITS-1:1]};
               bit_q <= bit_q + 1'b1;
`ifdef UART_RX_PARITY_EN
               if (bit_q == BW'(DATA_BITS - 1)) state_q <= PARITY;
`else
               if (bit_q == BW'(DATA_BITS - 1)) state_q <= STOP;
`endif
            end
`ifdef UART_RX_PARITY_EN
            PARITY: if (at_lim) begin
               par_q   <= rx_s_q;
               state_q <= STOP;
            end
`endif
            STOP: if (at_lim) begin
               busy_q  <= 1'b0;
               done_q  <= rx_s_q;
               ferr_q  <= !rx_s_q;
               state_q <= rx_s_q ? IDLE : BRK;
               if (rx_s_q) data_q <= sh_q;
`ifdef UART_RX_PARITY_EN
               perr_q  <= rx_s_q && (^sh_q ^ par_q);
`endif
            end
            // held-low line after a bad stop bit must not look like a new start
            BRK: begin
               tick_q <= '0;
               if (rx_s_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end
   assign bus.rx_data      = data_q;
   assign bus.rx_done      = done_q;
   assign bus.rx_frame_err = ferr_q;
   assign bus.rx_busy      = busy_q;
`ifdef UART_RX_PARITY_EN
   assign bus.rx_parity_err = perr_q;
`endif
endmodule
